// File: rtl/lcms_reset_seq_if.sv
// Configuration bus of the LCMS integrator reset sequencer.
// The master drives a load request together with the four timing words.
interface lcms_reset_seq_if #(
   parameter int CNT_W = 16
);
   logic             cfg_load_i;
   logic [CNT_W-1:0] reset_period_i;
   logic [CNT_W-1:0] int_reset_duration_i;
   logic [CNT_W-1:0] post_reset_duration_i;
   logic [CNT_W-1:0] v_sampling_period_i;

   modport master (
      output cfg_load_i,
      output reset_period_i,
      output int_reset_duration_i,
      output post_reset_duration_i,
      output v_sampling_period_i
   );

   modport slave (
      input cfg_load_i,
      input reset_period_i,
      input int_reset_duration_i,
      input post_reset_duration_i,
      input v_sampling_period_i
   );
endinterface

// File: rtl/lcms_reset_seq.sv
// N-channel integrator reset / sampling sequencer for the LCMS front end.
// A tick prescaler paces INT_RESET, POST_RESET, integrate and ADC strobes.
module lcms_reset_seq #(
   parameter int N_CH     = 4,
   parameter int CNT_W    = 16,
   parameter int TICK_DIV = 100
) (
   input  logic             s_clk,
   input  logic             a_rst_hard_n,
   input  logic             enable_i,
   input  logic             mode_i,
   input  logic             trig_i,
   lcms_reset_seq_if.slave  cfg,
   input  logic [N_CH-1:0]  ch_enable_i,
   output logic [N_CH-1:0]  INT_RESET,
   output logic [N_CH-1:0]  POST_RESET,
   output logic             sample_stb,
   output logic [CNT_W-1:0] samples_per_period,
   output logic             busy,
   output logic             cfg_err
);
   localparam int PSC_W = $clog2(TICK_DIV);
   localparam logic [PSC_W-1:0] PSC_TOP = PSC_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_IRST,
      S_PRST,
      S_INTEG
   } state_t;

   typedef struct packed {
      logic [CNT_W-1:0] per;
      logic [CNT_W-1:0] intd;
      logic [CNT_W-1:0] post;
      logic [CNT_W-1:0] samp;
   } cfg_t;

   localparam cfg_t CFG_RST = '{
      per:  CNT_W'(100),
      intd: CNT_W'(2),
      post: CNT_W'(3),
      samp: CNT_W'(10)
   };

   state_t           state_q, state_d;
   logic [PSC_W-1:0] psc_q, psc_d;
   logic [CNT_W-1:0] tcnt_q, tcnt_d;
   logic [CNT_W-1:0] scnt_q, scnt_d;
   logic [CNT_W-1:0] stbc_q, stbc_d;
   logic [CNT_W-1:0] spp_q, spp_d;
   cfg_t             pend_q, pend_d;
   cfg_t             act_q, act_d;
   logic             err_q, err_d;
   logic [N_CH-1:0]  int_q, post_q;
   logic             stb_q, busy_q;

   cfg_t             cfg_in;
   logic             cfg_ok;
   logic [CNT_W:0]   sum_in, rst_end, tcnt_nx;
   logic             tick, last, go, cont, stb_d;
   logic [CNT_W-1:0] nstb;

   always_comb begin
      cfg_in = '{
         per:  cfg.reset_period_i,
         intd: cfg.int_reset_duration_i,
         post: cfg.post_reset_duration_i,
         samp: cfg.v_sampling_period_i
      };
      // Sum is one bit wider so a huge int+post cannot wrap below period.
      sum_in = {1'b0, cfg_in.intd} + {1'b0, cfg_in.post};
      cfg_ok = (cfg_in.per != '0) && (cfg_in.samp != '0) &&
               (cfg_in.intd != '0) && (cfg_in.post != '0) &&
               (sum_in < {1'b0, cfg_in.per});
      pend_d = pend_q;
      err_d  = err_q;
      if (cfg.cfg_load_i) begin
         err_d = !cfg_ok;
         if (cfg_ok) pend_d = cfg_in;
      end

      tick    = (state_q != S_IDLE) && (psc_q == PSC_TOP);
      tcnt_nx = {1'b0, tcnt_q} + {1'b0, ONE};
      rst_end = {1'b0, act_q.intd} + {1'b0, act_q.post};
      last    = tick && (tcnt_nx == {1'b0, act_q.per});
      go      = mode_i ? trig_i : enable_i;
      cont    = !mode_i && enable_i;
      stb_d   = (state_q == S_INTEG) && tick &&
                (scnt_q == act_q.samp - ONE);

      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (go) state_d = S_IRST;
         S_IRST:  if (tick && tcnt_nx == {1'b0, act_q.intd})
                     state_d = S_PRST;
         S_PRST:  if (tick && tcnt_nx == rst_end)
                     state_d = S_INTEG;
         S_INTEG: if (last) state_d = cont ? S_IRST : S_IDLE;
         default: state_d = S_IDLE;
      endcase

      psc_d = (state_q == S_IDLE || tick) ? '0 : psc_q + PSC_W'(1);

      tcnt_d = tcnt_q;
      if (state_q == S_IDLE || last) tcnt_d = '0;
      else if (tick)                 tcnt_d = tcnt_nx[CNT_W-1:0];

      scnt_d = scnt_q;
      if (state_q != S_INTEG) scnt_d = '0;
      else if (tick)          scnt_d = stb_d ? '0 : scnt_q + ONE;

      nstb   = (stb_d && stbc_q != '1) ? stbc_q + ONE : stbc_q;
      stbc_d = (state_q == S_IDLE || last) ? '0 : nstb;
      spp_d  = last ? nstb : spp_q;

      // Active config only changes between periods.
      act_d = (state_q == S_IDLE || last) ? pend_d : act_q;
   end

   always_ff @(posedge s_clk or negedge a_rst_hard_n) begin
      if (!a_rst_hard_n) begin
         state_q <= S_IDLE;
         psc_q   <= '0;
         tcnt_q  <= '0;
         scnt_q  <= '0;
         stbc_q  <= '0;
         spp_q   <= '0;
         pend_q  <= CFG_RST;
         act_q   <= CFG_RST;
         err_q   <= 1'b0;
         int_q   <= '0;
         post_q  <= '0;
         stb_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         psc_q   <= psc_d;
         tcnt_q  <= tcnt_d;
         scnt_q  <= scnt_d;
         stbc_q  <= stbc_d;
         spp_q   <= spp_d;
         pend_q  <= pend_d;
         act_q   <= act_d;
         err_q   <= err_d;
         int_q   <= {N_CH{state_d == S_IRST}} & ch_enable_i;
         post_q  <= {N_CH{state_d == S_PRST}} & ch_enable_i;
         stb_q   <= stb_d;
         busy_q  <= state_d != S_IDLE;
      end
   end

   assign INT_RESET          = int_q;
   assign POST_RESET         = post_q;
   assign sample_stb         = stb_q;
   assign samples_per_period = spp_q;
   assign busy               = busy_q;
   assign cfg_err            = err_q;
endmodule

// File: tb/tb_lcms_reset_seq.sv
// Bench for lcms_reset_seq: table vectors, directed corner sequences and
// random stimulus against a period-timeline reference model.
module tb_lcms_reset_seq;
   localparam int N_CH  = 4;
   localparam int CNT_W = 16;
   localparam int TD    = 2;

   typedef struct { int p; int i; int po; int s; } cfg_t;
   typedef struct { int p; int i; int po; int s; bit err; } vec_t;

   logic s_clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic mode = 1'b0;
   logic trig = 1'b0;
   logic [N_CH-1:0] mask = '0;

   logic [N_CH-1:0]  INT_RESET, POST_RESET;
   logic             sample_stb, busy, cfg_err;
   logic [CNT_W-1:0] spp;

   lcms_reset_seq_if #(.CNT_W(CNT_W)) cfg_if ();

   lcms_reset_seq #(
      .N_CH(N_CH), .CNT_W(CNT_W), .TICK_DIV(TD)
   ) dut (
      .s_clk(s_clk),
      .a_rst_hard_n(rst_n),
      .enable_i(en),
      .mode_i(mode),
      .trig_i(trig),
      .cfg(cfg_if.slave),
      .ch_enable_i(mask),
      .INT_RESET(INT_RESET),
      .POST_RESET(POST_RESET),
      .sample_stb(sample_stb),
      .samples_per_period(spp),
      .busy(busy),
      .cfg_err(cfg_err)
   );

   always #5 s_clk = ~s_clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   int n_tot = 0;
   int n_bad = 0;

   // reference model: position within the current period, in s_clk cycles
   bit              m_run;
   int              m_k;
   cfg_t            m_act, m_pend;
   bit              m_err, m_stb;
   int              m_spp, m_nstb;
   logic [N_CH-1:0] m_mask;
   int c_int, c_post, c_stb, c_busy;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic model_reset();
      m_run  = 0;
      m_k    = 0;
      m_act  = '{100, 2, 3, 10};
      m_pend = '{100, 2, 3, 10};
      m_err  = 0;
      m_stb  = 0;
      m_spp  = 0;
      m_nstb = 0;
      m_mask = '0;
   endtask

   task automatic model_step();
      int p, i, po, s, jp, ib;
      bit ok;
      p  = int'(cfg_if.reset_period_i);
      i  = int'(cfg_if.int_reset_duration_i);
      po = int'(cfg_if.post_reset_duration_i);
      s  = int'(cfg_if.v_sampling_period_i);
      ok = p != 0 && s != 0 && i != 0 && po != 0 && (i + po) < p;
      if (cfg_if.cfg_load_i) begin
         m_err = !ok;
         if (ok) m_pend = '{p, i, po, s};
      end
      m_stb = 0;
      if (!m_run) begin
         m_act = m_pend;
         if (mode ? trig : en) begin
            m_run  = 1;
            m_k    = 0;
            m_nstb = 0;
         end
      end else begin
         m_k++;
         if (m_k % TD == 0) begin
            jp = m_k / TD - 1;
            ib = m_act.i + m_act.po;
            if (jp >= ib && (jp - ib + 1) % m_act.s == 0) begin
               m_stb = 1;
               if (m_nstb < 65535) m_nstb++;
            end
         end
         if (m_k == m_act.p * TD) begin
            m_spp  = m_nstb;
            m_nstb = 0;
            m_act  = m_pend;
            if (!mode && en) m_k = 0;
            else m_run = 0;
         end
      end
      m_mask = mask;
   endtask

   task automatic check_outputs();
      int j;
      logic [N_CH-1:0] ei, ep;
      j  = m_k / TD;
      ei = (m_run && j < m_act.i) ? m_mask : '0;
      ep = (m_run && j >= m_act.i && j < m_act.i + m_act.po) ? m_mask : '0;
      chk("int_reset", 64'(INT_RESET), 64'(ei));
      chk("post_reset", 64'(POST_RESET), 64'(ep));
      chk("sample_stb", 64'(sample_stb), 64'(m_stb));
      chk("busy", 64'(busy), 64'(m_run));
      chk("cfg_err", 64'(cfg_err), 64'(m_err));
      chk("spp", 64'(spp), 64'(m_spp));
      c_int  += int'(INT_RESET != '0);
      c_post += int'(POST_RESET != '0);
      c_stb  += int'(sample_stb);
      c_busy += int'(busy);
   endtask

   task automatic clr_counts();
      c_int = 0; c_post = 0; c_stb = 0; c_busy = 0;
   endtask

   task automatic cyc();
      @(posedge s_clk);
      model_step();
      @(negedge s_clk);
      check_outputs();
   endtask

   task automatic load_cfg(input int p, input int i, input int po, input int s);
      cfg_if.reset_period_i        = 16'(p);
      cfg_if.int_reset_duration_i  = 16'(i);
      cfg_if.post_reset_duration_i = 16'(po);
      cfg_if.v_sampling_period_i   = 16'(s);
      cfg_if.cfg_load_i            = 1'b1;
      cyc();
      cfg_if.cfg_load_i            = 1'b0;
   endtask

   task automatic align();
      bit ok;
      ok = 0;
      for (int n = 0; n < 200 && !ok; n++) begin
         cyc();
         ok = m_run && m_k == 0;
      end
      chk("align_timeout", 64'(ok), 64'(1));
   endtask

   task automatic wait_idle();
      bit ok;
      ok = !m_run;
      for (int n = 0; n < 400 && !ok; n++) begin
         cyc();
         ok = !m_run;
      end
      chk("idle_timeout", 64'(ok), 64'(1));
   endtask

   initial begin
      vec_t tbl[9];
      int s0, s1, r1, r2, nb, nmask, fall;
      bit prev;

      tbl[0] = '{10, 2, 3, 2, 1'b0};
      tbl[1] = '{5, 2, 3, 2, 1'b1};
      tbl[2] = '{0, 1, 1, 1, 1'b1};
      tbl[3] = '{10, 0, 3, 2, 1'b1};
      tbl[4] = '{10, 2, 0, 2, 1'b1};
      tbl[5] = '{10, 2, 3, 0, 1'b1};
      tbl[6] = '{65535, 65535, 1, 1, 1'b1};
      tbl[7] = '{6, 2, 3, 1, 1'b0};
      tbl[8] = '{10, 2, 3, 2, 1'b0};

      cfg_if.cfg_load_i            = 1'b0;
      cfg_if.reset_period_i        = '0;
      cfg_if.int_reset_duration_i  = '0;
      cfg_if.post_reset_duration_i = '0;
      cfg_if.v_sampling_period_i   = '0;
      model_reset();
      clr_counts();
      repeat (3) @(negedge s_clk);
      check_outputs();
      rst_n = 1'b1;

      // config validity table, applied in IDLE
      foreach (tbl[r]) begin
         load_cfg(tbl[r].p, tbl[r].i, tbl[r].po, tbl[r].s);
         chk("cfg_tbl", 64'(cfg_err), 64'(tbl[r].err));
      end

      // free-run timing over one exact period
      mask = 4'hF;
      load_cfg(10, 2, 3, 2);
      clr_counts();
      en = 1'b1;
      s0 = -1; s1 = -1;
      for (int n = 0; n < 20; n++) begin
         cyc();
         if (sample_stb) begin
            if (s0 < 0) s0 = n;
            else if (s1 < 0) s1 = n;
         end
      end
      chk("t1_int_cyc", 64'(c_int), 64'(4));
      chk("t1_post_cyc", 64'(c_post), 64'(6));
      chk("t1_stb_cnt", 64'(c_stb), 64'(2));
      chk("t1_stb0_at", 64'(s0), 64'(14));
      chk("t1_stb1_at", 64'(s1), 64'(18));
      chk("t1_busy_cyc", 64'(c_busy), 64'(20));
      cyc();
      chk("t1_restart", 64'(INT_RESET), 64'(4'hF));
      chk("t1_spp", 64'(spp), 64'(2));

      // rejected load leaves timing untouched
      load_cfg(5, 2, 3, 2);
      chk("t2_err_set", 64'(cfg_err), 64'(1));
      clr_counts();
      repeat (20) cyc();
      chk("t2_int_cyc", 64'(c_int), 64'(4));
      chk("t2_stb_cnt", 64'(c_stb), 64'(2));
      load_cfg(10, 2, 3, 2);
      chk("t2_err_clr", 64'(cfg_err), 64'(0));

      // reload mid-period takes effect only at the next period
      align();
      r1 = -1; r2 = -1; prev = 1'b1;
      for (int n = 1; n < 62; n++) begin
         if (n == 7) begin
            cfg_if.reset_period_i = 16'd20;
            cfg_if.cfg_load_i = 1'b1;
         end
         cyc();
         cfg_if.cfg_load_i = 1'b0;
         if (INT_RESET != '0 && !prev) begin
            if (r1 < 0) r1 = n;
            else if (r2 < 0) r2 = n;
         end
         prev = INT_RESET != '0;
      end
      chk("t4_first_end", 64'(r1), 64'(20));
      chk("t4_second_end", 64'(r2), 64'(60));
      load_cfg(10, 2, 3, 2);

      // masking and graceful stop
      mask = 4'b0101;
      align();
      chk("t5_int_mask", 64'(INT_RESET), 64'(4'b0101));
      nmask = 0; fall = -1;
      for (int n = 1; n < 40; n++) begin
         if (n == 9) en = 1'b0;
         cyc();
         if (((INT_RESET | POST_RESET) & 4'b1010) != '0) nmask++;
         if (!busy && fall < 0) fall = n;
      end
      chk("t5_masked_bits", 64'(nmask), 64'(0));
      chk("t5_stop_at", 64'(fall), 64'(20));
      chk("t5_idle_out", 64'({INT_RESET, POST_RESET, sample_stb}), 64'(0));

      // single shot, second trigger mid-period ignored
      mask = 4'hF;
      mode = 1'b1;
      clr_counts();
      trig = 1'b1;
      cyc();
      trig = 1'b0;
      for (int n = 1; n < 40; n++) begin
         trig = n == 8;
         cyc();
      end
      trig = 1'b0;
      chk("t3_busy_cyc", 64'(c_busy), 64'(20));
      chk("t3_end_idle", 64'(busy), 64'(0));
      en = 1'b1;
      clr_counts();
      repeat (6) cyc();
      chk("t3_en_in_m1", 64'(c_busy), 64'(0));
      en = 1'b0;
      mode = 1'b0;

      // random stimulus against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 29) == 0) begin
            cfg_if.reset_period_i        = 16'($urandom_range(0, 20));
            cfg_if.int_reset_duration_i  = 16'($urandom_range(0, 5));
            cfg_if.post_reset_duration_i = 16'($urandom_range(0, 5));
            cfg_if.v_sampling_period_i   = 16'($urandom_range(0, 6));
            cfg_if.cfg_load_i            = 1'b1;
         end
         if ($urandom_range(0, 49) == 0) en = ~en;
         if ($urandom_range(0, 99) == 0) mode = ~mode;
         trig = $urandom_range(0, 19) == 0;
         if ($urandom_range(0, 39) == 0) mask = 4'($urandom);
         cyc();
         cfg_if.cfg_load_i = 1'b0;
      end
      en = 1'b0; mode = 1'b0; trig = 1'b0;
      wait_idle();

      // async reset during POST_RST restores defaults
      mask = 4'hF;
      load_cfg(10, 2, 3, 2);
      en = 1'b1;
      repeat (6) cyc();
      chk("t6_in_post", 64'(POST_RESET), 64'(4'hF));
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_int", 64'(INT_RESET), 64'(0));
      chk("t6_rst_post", 64'(POST_RESET), 64'(0));
      chk("t6_rst_busy", 64'(busy), 64'(0));
      chk("t6_rst_stb", 64'(sample_stb), 64'(0));
      model_reset();
      en = 1'b0;
      @(negedge s_clk);
      rst_n = 1'b1;
      en = 1'b1;
      clr_counts();
      repeat (200) cyc();
      chk("t6_def_int", 64'(c_int), 64'(4));
      chk("t6_def_post", 64'(c_post), 64'(6));
      chk("t6_def_stb", 64'(c_stb), 64'(9));
      cyc();
      chk("t6_def_spp", 64'(spp), 64'(9));
      chk("t6_def_restart", 64'(INT_RESET), 64'(4'hF));
      en = 1'b0;
      wait_idle();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
